// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel timer: channel modes and FSM state encoding.
package timer_pkg;

  // Channel operating modes
  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  // Per-channel FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN/DONE FSM, latched period, tick counter and a
// registered one-cycle terminal pulse. Advances only on the shared prescaler tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] max_count,
  output logic             finish,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] latch_reg, latch_next;
  logic             finish_reg, finish_next;
  logic             period_ok;

  // A zero period is never latched, so the terminal compare (latch-1) cannot underflow.
  assign period_ok = (max_count != '0);

  // Next-state, counter, latch and pulse logic; en has priority over start, start over tick.
  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    latch_next  = latch_reg;
    finish_next = 1'b0;

    if (!en) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (period_ok && (mode == MODE_PERIODIC || start)) begin
            state_next = ST_RUN;
            count_next = '0;
            latch_next = max_count;
          end
        end

        ST_RUN: begin
          if (start) begin
            // Restart: no pulse this cycle. A zero period cannot be latched,
            // so the channel drops back to IDLE instead.
            count_next = '0;
            if (period_ok) begin
              latch_next = max_count;
            end else begin
              state_next = ST_IDLE;
            end
          end else if (tick) begin
            if (count_reg == (latch_reg - CNT_W'(1))) begin
              count_next  = '0;
              finish_next = 1'b1;
              if (mode == MODE_ONESHOT) begin
                state_next = ST_DONE;
              end else if (period_ok) begin
                // New period takes effect only at the wrap
                latch_next = max_count;
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              count_next = count_reg + CNT_W'(1);
            end
          end
        end

        ST_DONE: begin
          count_next = '0;
          if (start && period_ok) begin
            state_next = ST_RUN;
            latch_next = max_count;
          end
        end

        default: begin
          state_next = ST_IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  // State, counter, latch and pulse registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      count_reg  <= '0;
      latch_reg  <= '0;
      finish_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      latch_reg  <= latch_next;
      finish_reg <= finish_next;
    end
  end

  assign finish = finish_reg;
  assign busy   = (state_reg == ST_RUN);
  assign count  = count_reg;

endmodule

// File: rtl/timer_multi.sv
// Multi-channel timer: one free-running programmable prescaler feeding NUM_CH
// independent timer channels.
module timer_multi
  import timer_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 18,
  parameter int PRESC_W = 8
) (
  input  logic                    clkSignal,
  input  logic                    RST,
  input  logic [PRESC_W-1:0]      prescale,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] maxCount,
  output logic [NUM_CH-1:0]       clkFinish,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH*CNT_W-1:0] count
);

  logic [PRESC_W-1:0] pcnt_reg;
  logic               tick;

  // Equality compare: if prescale drops below pcnt, pcnt simply wraps around.
  assign tick = (pcnt_reg == prescale);

  // Free-running prescaler shared by all channels.
  always_ff @(posedge clkSignal or negedge RST) begin
    if (!RST) begin
      pcnt_reg <= '0;
    end else if (tick) begin
      pcnt_reg <= '0;
    end else begin
      pcnt_reg <= pcnt_reg + PRESC_W'(1);
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_channel #(
        .CNT_W(CNT_W)
      ) u_channel (
        .clk      (clkSignal),
        .rst_n    (RST),
        .tick     (tick),
        .en       (en[gi]),
        .start    (start[gi]),
        .mode     (mode[gi]),
        .max_count(maxCount[gi*CNT_W +: CNT_W]),
        .finish   (clkFinish[gi]),
        .busy     (busy[gi]),
        .count    (count[gi*CNT_W +: CNT_W])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: table-driven channel-0 scenarios plus
// hand-written corner sequences, with a queue of expected pulse cycles.
module tb_timer_multi;

  localparam int NUM_CH  = 4;
  localparam int CNT_W   = 18;
  localparam int PRESC_W = 8;

  logic                    clkSignal = 1'b0;
  logic                    RST;
  logic [PRESC_W-1:0]      prescale;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       start;
  logic [NUM_CH-1:0]       mode;
  logic [NUM_CH*CNT_W-1:0] maxCount;
  logic [NUM_CH-1:0]       clkFinish;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH*CNT_W-1:0] count;

  timer_multi #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .PRESC_W(PRESC_W)
  ) dut (
    .clkSignal(clkSignal),
    .RST      (RST),
    .prescale (prescale),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .maxCount (maxCount),
    .clkFinish(clkFinish),
    .busy     (busy),
    .count    (count)
  );

  always #5 clkSignal = ~clkSignal;

  // Scenario record: inputs for channel 0 and the expected outcome.
  // Cycle k means "sampled on the falling edge after the k-th rising edge since reset release".
  typedef struct {
    logic mode;
    int   presc;
    int   maxc;
    int   first;     // cycle of the first expected pulse
    int   period;    // cycles between pulses
    int   npulse;    // pulses expected inside the window
    int   window;    // cycles observed
    int   busy_cyc;  // cycles with busy[0] high
    int   cnt_max;   // largest count[0] observed
  } vec_t;

  vec_t vecs[7];
  int   exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_seen, cnt_seen, stray, other_act, pulses_seen;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_pulses(input int first, input int period, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(first + i * period);
  endtask

  task automatic clear_stats();
    busy_seen   = 0;
    cnt_seen    = 0;
    stray       = 0;
    other_act   = 0;
    pulses_seen = 0;
  endtask

  // Compare one cycle of DUT output against the scoreboard.
  task automatic observe(input int k);
    if (clkFinish[0]) begin
      pulses_seen++;
      if (exp_q.size() == 0) check("unexpected_pulse", k, -1);
      else check("pulse_cycle", k, exp_q.pop_front());
    end
    if (clkFinish[NUM_CH-1:1] != '0) stray++;
    if (busy[NUM_CH-1:1] != '0 || count[NUM_CH*CNT_W-1:CNT_W] != '0) other_act++;
    if (busy[0]) busy_seen++;
    if (int'(count[CNT_W-1:0]) > cnt_seen) cnt_seen = int'(count[CNT_W-1:0]);
  endtask

  // Advance through cycles first_k..last_k; any start strobe lasts one edge.
  task automatic run(input int first_k, input int last_k);
    for (int k = first_k; k <= last_k; k++) begin
      @(posedge clkSignal);
      @(negedge clkSignal);
      start = '0;
      observe(k);
    end
  endtask

  task automatic end_window(input string tag);
    check({tag, "_pending_pulses"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_other_channels"}, stray + other_act, 0);
  endtask

  task automatic apply_reset();
    @(negedge clkSignal);
    RST      = 1'b0;
    en       = '0;
    start    = '0;
    mode     = '0;
    maxCount = '0;
    prescale = '0;
    @(negedge clkSignal);
  endtask

  // Release reset and arm channel 0 on the same falling edge.
  task automatic arm(input logic m, input int p, input int mc);
    RST                 = 1'b1;
    prescale            = PRESC_W'(p);
    mode[0]             = m;
    maxCount[CNT_W-1:0] = CNT_W'(mc);
    en[0]               = 1'b1;
    start[0]            = m;
    clear_stats();
  endtask

  initial begin
    vecs[0] = '{1'b0, 0, 5, 6, 5, 4, 25, 25, 4};
    vecs[1] = '{1'b1, 0, 3, 4, 0, 1, 25, 3, 2};
    vecs[2] = '{1'b0, 3, 2, 8, 8, 5, 44, 44, 1};
    vecs[3] = '{1'b0, 0, 1, 2, 1, 20, 21, 21, 0};
    vecs[4] = '{1'b0, 0, 0, 0, 0, 0, 20, 0, 0};
    vecs[5] = '{1'b1, 1, 2, 4, 0, 1, 20, 3, 1};
    vecs[6] = '{1'b0, 2, 3, 9, 9, 3, 28, 28, 2};

    // Reset state
    RST = 1'b0; en = '0; start = '0; mode = '0; maxCount = '0; prescale = '0;
    apply_reset();
    check("rst_finish", int'(clkFinish != '0), 0);
    check("rst_busy", int'(busy != '0), 0);
    check("rst_count", int'(count != '0), 0);

    // Asynchronous reset in the middle of a run
    arm(1'b0, 0, 5);
    run(1, 4);
    check("cnt_before_async_rst", int'(count[CNT_W-1:0]), 3);
    #2 RST = 1'b0;
    en = '0;
    #1;
    check("async_rst_finish", int'(clkFinish != '0), 0);
    check("async_rst_busy", int'(busy != '0), 0);
    check("async_rst_count", int'(count != '0), 0);
    @(negedge clkSignal);
    RST = 1'b1;
    clear_stats();
    run(1, 5);
    check("after_rst_busy", busy_seen, 0);
    check("after_rst_count", cnt_seen, 0);
    end_window("after_rst");
    $display("seq async_reset: count cleared, idle after release");

    // Table-driven scenarios on channel 0
    for (int v = 0; v < 7; v++) begin
      apply_reset();
      arm(vecs[v].mode, vecs[v].presc, vecs[v].maxc);
      push_pulses(vecs[v].first, vecs[v].period, vecs[v].npulse);
      run(1, vecs[v].window);
      end_window($sformatf("vec%0d", v));
      check($sformatf("vec%0d_busy_cycles", v), busy_seen, vecs[v].busy_cyc);
      check($sformatf("vec%0d_count_max", v), cnt_seen, vecs[v].cnt_max);
      $display("vec %0d: mode=%0d prescale=%0d maxCount=%0d pulses=%0d busy_cycles=%0d",
               v, vecs[v].mode, vecs[v].presc, vecs[v].maxc, pulses_seen, busy_seen);
    end

    // One-shot: second start after DONE yields exactly one more pulse
    apply_reset();
    arm(1'b1, 0, 3);
    push_pulses(4, 0, 1);
    run(1, 25);
    start[0] = 1'b1;
    push_pulses(29, 0, 1);
    run(26, 40);
    end_window("oneshot_restart");
    check("oneshot_restart_busy", busy_seen, 6);
    $display("seq oneshot_restart: pulses=%0d busy_cycles=%0d", pulses_seen, busy_seen);

    // maxCount 5 -> 2 during RUN applies at the next wrap
    apply_reset();
    arm(1'b0, 0, 5);
    push_pulses(6, 0, 1);
    push_pulses(8, 2, 3);
    run(1, 3);
    maxCount[CNT_W-1:0] = CNT_W'(2);
    run(4, 13);
    end_window("maxcount_change");
    $display("seq maxcount_change: pulses=%0d", pulses_seen);

    // Start on the terminal tick restarts without a pulse
    apply_reset();
    arm(1'b0, 0, 5);
    run(1, 5);
    start[0] = 1'b1;
    push_pulses(11, 5, 2);
    run(6, 6);
    check("term_start_count", int'(count[CNT_W-1:0]), 0);
    run(7, 17);
    end_window("term_start");
    $display("seq start_on_terminal: pulses=%0d", pulses_seen);

    // en=0 together with start=1 forces IDLE
    apply_reset();
    arm(1'b0, 0, 5);
    run(1, 3);
    en[0]    = 1'b0;
    start[0] = 1'b1;
    run(4, 4);
    check("en_over_start_busy", int'(busy[0]), 0);
    check("en_over_start_count", int'(count[CNT_W-1:0]), 0);
    busy_seen = 0;
    run(5, 8);
    check("en_over_start_stays_idle", busy_seen, 0);
    end_window("en_over_start");
    $display("seq en_over_start: busy=%0d", busy[0]);

    // Channel 0 running leaves an armed-but-unstarted one-shot channel 1 idle
    apply_reset();
    arm(1'b0, 0, 3);
    mode[1]                   = 1'b1;
    en[1]                     = 1'b1;
    maxCount[CNT_W +: CNT_W]  = CNT_W'(4);
    push_pulses(4, 3, 4);
    run(1, 14);
    end_window("isolation");
    check("isolation_ch0_busy", busy_seen, 14);
    $display("seq isolation: ch0 pulses=%0d ch1 activity=%0d", pulses_seen, other_act + stray);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
